// File: rtl/scroll_sequencer.sv
// Scroll position sequencer: prescaled step tick, message position index and
// run/pause/step/restart control for the scrolling seven-segment display.
module scroll_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CW       = 26,
    parameter int LEN      = 9,
    parameter int PW       = 4
) (
    input  logic          clk,
    input  logic          Clr,
    input  logic          en,
    input  logic          dir,
    input  logic [1:0]    speed,
    input  logic          step,
    input  logic          restart,
    output logic [PW-1:0] pos,
    output logic          tick,
    output logic          wrap,
    output logic          running
);

    localparam logic [1:0]    IDLE  = 2'd0;
    localparam logic [1:0]    RUN   = 2'd1;
    localparam logic [1:0]    PAUSE = 2'd2;
    localparam logic [CW-1:0] DIV   = CW'(TICK_DIV);
    localparam logic [PW-1:0] LAST  = PW'(LEN - 1);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] pos_reg, pos_next, pos_adv;
    logic          tick_reg, tick_next;
    logic          wrap_reg, wrap_next, wrap_adv;
    logic          running_reg;
    logic [CW-1:0] period, term;
    logic          terminal, step_ok;

    // A very high speed setting can shift the period to zero; treat it as 1.
    assign period   = DIV >> speed;
    assign term     = (period == '0) ? '0 : period - CW'(1);
    assign terminal = (cnt_reg >= term);
    assign step_ok  = step && (state_reg == PAUSE || (state_reg == IDLE && !en));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = PAUSE;
            PAUSE:   if (en)  state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Single advance rule shared by the prescaler tick and the step pulse.
    always_comb begin
        pos_adv  = pos_reg;
        wrap_adv = 1'b0;
        if (!dir) begin
            if (pos_reg >= LAST) begin
                pos_adv  = '0;
                wrap_adv = 1'b1;
            end else begin
                pos_adv = pos_reg + PW'(1);
            end
        end else begin
            if (pos_reg == '0 || pos_reg > LAST) begin
                pos_adv  = LAST;
                wrap_adv = 1'b1;
            end else begin
                pos_adv = pos_reg - PW'(1);
            end
        end
    end

    always_comb begin
        cnt_next  = cnt_reg;
        pos_next  = pos_reg;
        tick_next = 1'b0;
        wrap_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (terminal) begin
                    cnt_next  = '0;
                    pos_next  = pos_adv;
                    tick_next = 1'b1;
                    wrap_next = wrap_adv;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            PAUSE: begin
                if (step_ok) begin
                    pos_next  = pos_adv;
                    tick_next = 1'b1;
                    wrap_next = wrap_adv;
                end
            end
            default: begin
                cnt_next = '0;
                if (step_ok) begin
                    pos_next  = pos_adv;
                    tick_next = 1'b1;
                    wrap_next = wrap_adv;
                end
            end
        endcase
        // restart overrides both the terminal count and a step; state is untouched.
        if (restart) begin
            cnt_next  = '0;
            pos_next  = '0;
            tick_next = 1'b0;
            wrap_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Clr) begin
        if (Clr) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pos_reg     <= '0;
            tick_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pos_reg     <= pos_next;
            tick_reg    <= tick_next;
            wrap_reg    <= wrap_next;
            running_reg <= (state_next == RUN);
        end
    end

    assign pos     = pos_reg;
    assign tick    = tick_reg;
    assign wrap    = wrap_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer with TICK_DIV=8, LEN=9: a vector table
// for idle stepping/restart plus hand sequences for run, pause, speed and reset.
module tb_scroll_sequencer;

    logic       clk = 1'b0;
    logic       Clr;
    logic       en, dir, step, restart;
    logic [1:0] speed;
    logic [3:0] pos;
    logic       tick, wrap, running;

    int tests = 0;
    int fails = 0;
    int nticks;

    typedef struct {
        logic       en;
        logic       dir;
        logic       step;
        logic       restart;
        logic [3:0] pos;
        logic       tick;
        logic       wrap;
        logic       running;
    } vec_t;

    vec_t vecs[12];

    scroll_sequencer #(.TICK_DIV(8), .CW(4), .LEN(9), .PW(4)) dut (
        .clk(clk), .Clr(Clr), .en(en), .dir(dir), .speed(speed),
        .step(step), .restart(restart),
        .pos(pos), .tick(tick), .wrap(wrap), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int p, input int t, input int w, input int r);
        chk({name, " pos"}, int'(pos), p);
        chk({name, " tick"}, int'(tick), t);
        chk({name, " wrap"}, int'(wrap), w);
        chk({name, " running"}, int'(running), r);
    endtask

    task automatic do_reset();
        Clr = 1'b1;
        en = 1'b0; dir = 1'b0; step = 1'b0; restart = 1'b0; speed = 2'd0;
        cyc();
        Clr = 1'b0;
    endtask

    initial begin
        //          en    dir   step  restart pos    tick  wrap  running
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk_out("reset", 0, 0, 0, 0);

        // Idle with en=0: nothing moves.
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_out("idle", 0, 0, 0, 0);
        end
        $display("[TB] idle 20 cycles pos=%0d", pos);

        // Vector table: stepping, restart priority, step ignored on RUN entry / in RUN.
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en; dir = vecs[i].dir;
            step = vecs[i].step; restart = vecs[i].restart;
            cyc();
            step = 1'b0; restart = 1'b0;
            $display("[TB] vec %0d pos=%0d tick=%0d wrap=%0d running=%0d", i, pos, tick, wrap, running);
            chk_out($sformatf("vec%0d", i), int'(vecs[i].pos), int'(vecs[i].tick),
                    int'(vecs[i].wrap), int'(vecs[i].running));
        end

        // Run up with wrap: tick every 8 cycles after the RUN entry edge.
        do_reset();
        en = 1'b1;
        cyc();
        chk_out("run entry", 0, 0, 0, 1);
        nticks = 0;
        for (int k = 1; k <= 72; k++) begin
            cyc();
            if (tick) nticks++;
            chk_out($sformatf("run k%0d", k), (k / 8) % 9, (k % 8 == 0) ? 1 : 0, (k == 72) ? 1 : 0, 1);
        end
        chk("tick count 72 cycles", nticks, 9);
        $display("[TB] run-up ticks=%0d pos=%0d", nticks, pos);

        // Reverse from 0: wraps to 8.
        dir = 1'b1;
        for (int k = 73; k <= 80; k++) begin
            cyc();
            chk_out($sformatf("down k%0d", k), (k == 80) ? 8 : 0, (k == 80) ? 1 : 0, (k == 80) ? 1 : 0, 1);
        end
        $display("[TB] dir=1 pos=%0d", pos);

        // speed=2: period 2.
        speed = 2'd2;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            chk_out($sformatf("spd2 j%0d", j), (j < 2) ? 8 : ((j < 4) ? 7 : 6), (j % 2 == 0) ? 1 : 0, 0, 1);
        end

        // speed 0 up to cnt=5, then speed 3: immediate tick then every cycle.
        speed = 2'd0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk_out($sformatf("spd0 j%0d", j), 6, 0, 0, 1);
        end
        speed = 2'd3;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk_out($sformatf("spd3 j%0d", j), 5 - j, 1, 0, 1);
        end
        $display("[TB] speed change pos=%0d", pos);

        // Asynchronous clear mid-run.
        #2;
        Clr = 1'b1;
        #1;
        chk_out("async clr", 0, 0, 0, 0);
        en = 1'b0; dir = 1'b0; speed = 2'd0;
        #1;
        Clr = 1'b0;
        cyc();
        chk_out("after clr", 0, 0, 0, 0);
        $display("[TB] async clear pos=%0d running=%0d", pos, running);

        // Pause at cnt=3, resume after 50 cycles, tick completes the partial period.
        en = 1'b1;
        cyc();
        for (int j = 1; j <= 3; j++) begin
            cyc();
            chk_out($sformatf("pre-pause j%0d", j), 0, 0, 0, 1);
        end
        en = 1'b0;
        cyc();
        chk_out("pause entry", 0, 0, 0, 0);
        for (int j = 0; j < 50; j++) begin
            cyc();
            chk_out("paused", 0, 0, 0, 0);
        end
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk_out($sformatf("resume r%0d", j), 0, 0, 0, 1);
        end
        cyc();
        chk_out("resume tick", 1, 1, 0, 1);
        $display("[TB] pause/resume pos=%0d", pos);

        // Step in PAUSE up to 8, then wrap to 0.
        en = 1'b0;
        cyc();
        chk_out("pause2", 1, 0, 0, 0);
        step = 1'b1;
        for (int j = 2; j <= 8; j++) begin
            cyc();
            chk_out($sformatf("pstep %0d", j), j, 1, 0, 0);
        end
        cyc();
        chk_out("pstep wrap", 0, 1, 1, 0);
        step = 1'b0;
        cyc();
        chk_out("pstep after", 0, 0, 0, 0);
        $display("[TB] pause step wrap pos=%0d", pos);

        // Restart coincident with a terminal count at pos=4.
        step = 1'b1;
        repeat (4) cyc();
        step = 1'b0;
        chk("pos before restart", int'(pos), 4);
        en = 1'b1;
        cyc();
        for (int j = 1; j <= 6; j++) begin
            cyc();
            chk_out($sformatf("pre-restart s%0d", j), 4, 0, 0, 1);
        end
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk_out("restart", 0, 0, 0, 1);
        for (int j = 8; j <= 14; j++) begin
            cyc();
            chk_out($sformatf("post-restart s%0d", j), 0, 0, 0, 1);
        end
        cyc();
        chk_out("post-restart tick", 1, 1, 0, 1);
        $display("[TB] restart pos=%0d tick=%0d", pos, tick);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
